// File: rtl/fp_ext_pipe.sv
// Operand-extension stage: unpacks half/single/double into {sign, exp[11:0] bias 2047, frac[51:0]}.
// Two-entry valid/ready pipeline that also produces FCLASS, the NaN-box check and the illegal-format flag.
module fp_ext_pipe #(
  parameter int unsigned TAG_W      = 4,
  parameter bit          NANBOX_CHK = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fp_ext_pipe_i_valid,
  output logic             fp_ext_pipe_o_ready,
  input  logic [63:0]      fp_ext_pipe_i_data,
  input  logic [1:0]       fp_ext_pipe_i_fmt,
  input  logic [TAG_W-1:0] fp_ext_pipe_i_tag,
  output logic             fp_ext_pipe_o_valid,
  input  logic             fp_ext_pipe_i_ready,
  output logic [64:0]      fp_ext_pipe_o_result,
  output logic [9:0]       fp_ext_pipe_o_classification,
  output logic             fp_ext_pipe_o_illegal,
  output logic [TAG_W-1:0] fp_ext_pipe_o_tag
);

  localparam logic [1:0] FMT_S = 2'd0;
  localparam logic [1:0] FMT_D = 2'd1;
  localparam logic [1:0] FMT_H = 2'd2;
  localparam logic [1:0] FMT_X = 2'd3;

  function automatic logic [5:0] lzc52(input logic [51:0] f);
    logic [5:0] n;
    n = '0;
    for (int unsigned i = 0; i < 52; i++) begin
      if (f[i]) n = 6'(51 - i);
    end
    return n;
  endfunction

  // Input decode, registered into S1
  logic        w_sign;
  logic [10:0] w_expf;
  logic [51:0] w_frac;
  logic        w_box_ok;
  logic [5:0]  w_lzc;

  always_comb begin
    w_sign   = 1'b0;
    w_expf   = '0;
    w_frac   = '0;
    w_box_ok = 1'b1;
    case (fp_ext_pipe_i_fmt)
      FMT_S: begin
        w_sign   = fp_ext_pipe_i_data[31];
        w_expf   = {3'b000, fp_ext_pipe_i_data[30:23]};
        w_frac   = {fp_ext_pipe_i_data[22:0], 29'b0};
        w_box_ok = (&fp_ext_pipe_i_data[63:32]) || !NANBOX_CHK;
      end
      FMT_D: begin
        w_sign = fp_ext_pipe_i_data[63];
        w_expf = fp_ext_pipe_i_data[62:52];
        w_frac = fp_ext_pipe_i_data[51:0];
      end
      FMT_H: begin
        w_sign   = fp_ext_pipe_i_data[15];
        w_expf   = {6'b000000, fp_ext_pipe_i_data[14:10]};
        w_frac   = {fp_ext_pipe_i_data[9:0], 42'b0};
        w_box_ok = (&fp_ext_pipe_i_data[63:16]) || !NANBOX_CHK;
      end
      default: ;
    endcase
    w_lzc = lzc52(w_frac);
  end

  logic             r_s1_valid;
  logic             r_s1_sign;
  logic [10:0]      r_s1_expf;
  logic [51:0]      r_s1_frac;
  logic [1:0]       r_s1_fmt;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s1_box_ok;
  logic [5:0]       r_s1_lzc;

  logic             r_s2_valid;
  logic [64:0]      r_s2_result;
  logic [9:0]       r_s2_cls;
  logic             r_s2_ill;
  logic [TAG_W-1:0] r_s2_tag;

  logic w_s2_load;
  logic w_s1_adv;
  logic w_in_xfer;

  assign w_s2_load           = !r_s2_valid || fp_ext_pipe_i_ready;
  assign w_s1_adv            = r_s1_valid && w_s2_load;
  assign fp_ext_pipe_o_ready = !r_s1_valid || w_s2_load;
  assign w_in_xfer           = fp_ext_pipe_i_valid && fp_ext_pipe_o_ready;

  // S2 combinational: normalise and classify from S1
  logic [11:0] w_offset;
  logic [10:0] w_exp_max;
  logic        w_exp_zero;
  logic        w_exp_ones;
  logic        w_frac_zero;
  logic [51:0] w_sub_frac;
  logic [64:0] w_res;
  logic [9:0]  w_cls;
  logic        w_ill;

  always_comb begin
    w_offset  = 12'h780;
    w_exp_max = 11'h0FF;
    case (r_s1_fmt)
      FMT_D: begin
        w_offset  = 12'h400;
        w_exp_max = 11'h7FF;
      end
      FMT_H: begin
        w_offset  = 12'h7F0;
        w_exp_max = 11'h01F;
      end
      default: ;
    endcase
    w_exp_zero  = (r_s1_expf == 11'h000);
    w_exp_ones  = (r_s1_expf == w_exp_max);
    w_frac_zero = (r_s1_frac == 52'h0);
    // Shifting by lzc+1 pushes the leading one out, leaving it implicit
    w_sub_frac  = r_s1_frac << (7'(r_s1_lzc) + 7'd1);

    w_res = '0;
    w_cls = '0;
    w_ill = 1'b0;
    if (r_s1_fmt == FMT_X) begin
      w_ill = 1'b1;
    end else if (!r_s1_box_ok) begin
      w_res = {1'b0, 12'hFFF, 1'b1, 51'b0};
      w_cls = 10'h200;
    end else if (w_exp_ones) begin
      w_res = {r_s1_sign, 12'hFFF, r_s1_frac};
      if (w_frac_zero) w_cls = r_s1_sign ? 10'h001 : 10'h080;
      else             w_cls = r_s1_frac[51] ? 10'h200 : 10'h100;
    end else if (w_exp_zero) begin
      if (w_frac_zero) begin
        w_res = {r_s1_sign, 64'b0};
        w_cls = r_s1_sign ? 10'h008 : 10'h010;
      end else begin
        w_res = {r_s1_sign, w_offset - {6'b000000, r_s1_lzc}, w_sub_frac};
        w_cls = r_s1_sign ? 10'h004 : 10'h020;
      end
    end else begin
      w_res = {r_s1_sign, w_offset + {1'b0, r_s1_expf}, r_s1_frac};
      w_cls = r_s1_sign ? 10'h002 : 10'h040;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_expf   <= '0;
      r_s1_frac   <= '0;
      r_s1_fmt    <= '0;
      r_s1_tag    <= '0;
      r_s1_box_ok <= 1'b0;
      r_s1_lzc    <= '0;
    end else begin
      if (fp_ext_pipe_o_ready) r_s1_valid <= fp_ext_pipe_i_valid;
      if (w_in_xfer) begin
        r_s1_sign   <= w_sign;
        r_s1_expf   <= w_expf;
        r_s1_frac   <= w_frac;
        r_s1_fmt    <= fp_ext_pipe_i_fmt;
        r_s1_tag    <= fp_ext_pipe_i_tag;
        r_s1_box_ok <= w_box_ok;
        r_s1_lzc    <= w_lzc;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s2_valid  <= 1'b0;
      r_s2_result <= '0;
      r_s2_cls    <= '0;
      r_s2_ill    <= 1'b0;
      r_s2_tag    <= '0;
    end else begin
      if (w_s2_load) r_s2_valid <= r_s1_valid;
      if (w_s1_adv) begin
        r_s2_result <= w_res;
        r_s2_cls    <= w_cls;
        r_s2_ill    <= w_ill;
        r_s2_tag    <= r_s1_tag;
      end
    end
  end

  assign fp_ext_pipe_o_valid          = r_s2_valid;
  assign fp_ext_pipe_o_result         = r_s2_result;
  assign fp_ext_pipe_o_classification = r_s2_cls;
  assign fp_ext_pipe_o_illegal        = r_s2_ill;
  assign fp_ext_pipe_o_tag            = r_s2_tag;

endmodule

// File: tb/tb_fp_ext_pipe.sv
// Directed table-driven bench for fp_ext_pipe: single-shot latency, stalled streams, reset flush.
module tb_fp_ext_pipe;

  localparam int unsigned TAG_W = 4;
  localparam int NV = 20;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             iv, ir;
  logic [63:0]      d;
  logic [1:0]       fmt;
  logic [TAG_W-1:0] tag;
  logic             o_ready, o_valid, o_ill;
  logic [64:0]      o_result;
  logic [9:0]       o_class;
  logic [TAG_W-1:0] o_tag;

  fp_ext_pipe #(.TAG_W(TAG_W), .NANBOX_CHK(1'b1)) dut (
    .clock                        (clock),
    .reset                        (reset),
    .fp_ext_pipe_i_valid          (iv),
    .fp_ext_pipe_o_ready          (o_ready),
    .fp_ext_pipe_i_data           (d),
    .fp_ext_pipe_i_fmt            (fmt),
    .fp_ext_pipe_i_tag            (tag),
    .fp_ext_pipe_o_valid          (o_valid),
    .fp_ext_pipe_i_ready          (ir),
    .fp_ext_pipe_o_result         (o_result),
    .fp_ext_pipe_o_classification (o_class),
    .fp_ext_pipe_o_illegal        (o_ill),
    .fp_ext_pipe_o_tag            (o_tag)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0]      data;
    logic [1:0]       fmt;
    logic [TAG_W-1:0] tag;
    logic [64:0]      res;
    logic [9:0]       cls;
    logic             ill;
  } vec_t;

  vec_t vec [NV];
  int checks   = 0;
  int failures = 0;
  int inflight = 0;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Pushes n table entries starting at 'first'; spaced=1 sends one at a time, stall=1 toggles i_ready 1,0,0,1.
  task automatic run(input int first, input int n, input bit stall, input bit spaced);
    int q[$];
    int sent = 0, got = 0, cyc = 0, acc_cyc = 0;
    bit p_stall = 1'b0;
    logic [64:0] p_res = '0;
    logic [9:0]  p_cls = '0;
    logic [TAG_W-1:0] p_tag = '0;
    inflight = 0;
    while (got < n && cyc < 400) begin
      @(negedge clock);
      ir = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (sent < n && (!spaced || inflight == 0)) begin
        d   = vec[first+sent].data;
        fmt = vec[first+sent].fmt;
        tag = vec[first+sent].tag;
        iv  = 1'b1;
      end else begin
        iv = 1'b0;
      end
      #1;
      chk($sformatf("o_ready c%0d", cyc), 65'(o_ready), 65'(!(inflight == 2 && !ir)));
      if (p_stall) begin
        chk("hold_valid", 65'(o_valid), 65'(1));
        chk("hold_result", o_result, p_res);
        chk("hold_class", 65'(o_class), 65'(p_cls));
        chk("hold_tag", 65'(o_tag), 65'(p_tag));
      end
      if (o_valid && ir) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_output: got tag %0d expected no output", o_tag);
        end else begin
          int k;
          k = q.pop_front();
          chk($sformatf("result v%0d", k), o_result, vec[k].res);
          chk($sformatf("class v%0d", k), 65'(o_class), 65'(vec[k].cls));
          chk($sformatf("illegal v%0d", k), 65'(o_ill), 65'(vec[k].ill));
          chk($sformatf("tag v%0d", k), 65'(o_tag), 65'(vec[k].tag));
          if (spaced) chk($sformatf("latency v%0d", k), 65'(cyc - acc_cyc), 65'(2));
          got++;
          inflight--;
        end
      end
      if (iv && o_ready) begin
        q.push_back(first + sent);
        sent++;
        inflight++;
        acc_cyc = cyc;
      end
      p_stall = o_valid && !ir;
      p_res   = o_result;
      p_cls   = o_class;
      p_tag   = o_tag;
      cyc++;
    end
    iv = 1'b0;
    ir = 1'b1;
    if (got < n) begin
      checks++;
      failures++;
      $display("FAIL timeout: got %0d outputs expected %0d", got, n);
    end
    repeat (3) begin
      @(negedge clock);
      #1 chk("drain_idle", 65'(o_valid), 65'(0));
    end
  endtask

  initial begin
    iv = 1'b0; ir = 1'b1; d = '0; fmt = '0; tag = '0;
    vec[0]  = '{64'hFFFFFFFF3F800000, 2'd0, 4'd5,  65'h0_7FF_0000000000000, 10'h040, 1'b0};
    vec[1]  = '{64'h8000000000000000, 2'd1, 4'd1,  65'h1_000_0000000000000, 10'h008, 1'b0};
    vec[2]  = '{64'hFFFFFFFF00000001, 2'd0, 4'd2,  65'h0_76A_0000000000000, 10'h020, 1'b0};
    vec[3]  = '{64'hFFFFFFFF00400000, 2'd0, 4'd3,  65'h0_780_0000000000000, 10'h020, 1'b0};
    vec[4]  = '{64'hFFFFFFFFFFFF7C01, 2'd2, 4'd4,  65'h0_FFF_0040000000000, 10'h100, 1'b0};
    vec[5]  = '{64'h000000003F800000, 2'd0, 4'd5,  65'h0_FFF_8000000000000, 10'h200, 1'b0};
    vec[6]  = '{64'h7FF0000000000000, 2'd1, 4'd6,  65'h0_FFF_0000000000000, 10'h080, 1'b0};
    vec[7]  = '{64'hFFF0000000000000, 2'd1, 4'd7,  65'h1_FFF_0000000000000, 10'h001, 1'b0};
    vec[8]  = '{64'hFFFFFFFFFFFFBC00, 2'd2, 4'd8,  65'h1_7FF_0000000000000, 10'h002, 1'b0};
    vec[9]  = '{64'hFFFFFFFFFFFF0000, 2'd2, 4'd9,  65'h0_000_0000000000000, 10'h010, 1'b0};
    vec[10] = '{64'h7FF8000000000000, 2'd1, 4'd10, 65'h0_FFF_8000000000000, 10'h200, 1'b0};
    vec[11] = '{64'h0000000000000001, 2'd1, 4'd11, 65'h0_3CD_0000000000000, 10'h020, 1'b0};
    vec[12] = '{64'hFFFFFFFF80000003, 2'd0, 4'd12, 65'h1_76B_8000000000000, 10'h004, 1'b0};
    vec[13] = '{64'h1234567890ABCDEF, 2'd3, 4'd13, 65'h0_000_0000000000000, 10'h000, 1'b1};
    vec[14] = '{64'hFFFFFFFFFFFF0200, 2'd2, 4'd14, 65'h0_7F0_0000000000000, 10'h020, 1'b0};
    vec[15] = '{64'hFFFFFFFFFFFF3E00, 2'd2, 4'd15, 65'h0_7FF_8000000000000, 10'h040, 1'b0};
    vec[16] = '{64'h4000000000000000, 2'd1, 4'd0,  65'h0_800_0000000000000, 10'h040, 1'b0};
    vec[17] = '{64'hFFFFFFFF00003C00, 2'd2, 4'd1,  65'h0_FFF_8000000000000, 10'h200, 1'b0};
    vec[18] = '{64'hFFFFFFFFFF800000, 2'd0, 4'd2,  65'h1_FFF_0000000000000, 10'h001, 1'b0};
    vec[19] = '{64'hFFFFFFFFC0490FDB, 2'd0, 4'd3,  65'h1_800_921FB60000000, 10'h002, 1'b0};

    #1;
    chk("rst_valid", 65'(o_valid), 65'(0));
    chk("rst_result", o_result, 65'(0));
    chk("rst_class", 65'(o_class), 65'(0));
    chk("rst_illegal", 65'(o_ill), 65'(0));
    chk("rst_tag", 65'(o_tag), 65'(0));
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("post_rst_ready", 65'(o_ready), 65'(1));
    chk("post_rst_valid", 65'(o_valid), 65'(0));

    run(0, NV, 1'b0, 1'b1);
    run(6, 8, 1'b1, 1'b0);
    run(0, NV, 1'b1, 1'b0);

    // Two operands in flight under backpressure, then asynchronous reset
    @(negedge clock);
    ir = 1'b0; iv = 1'b1; d = vec[1].data; fmt = vec[1].fmt; tag = vec[1].tag;
    @(negedge clock);
    d = vec[2].data; fmt = vec[2].fmt; tag = vec[2].tag;
    @(negedge clock);
    iv = 1'b0;
    #1;
    chk("inflight_valid", 65'(o_valid), 65'(1));
    chk("inflight_full_ready", 65'(o_ready), 65'(0));
    chk("inflight_tag", 65'(o_tag), 65'(vec[1].tag));
    #1 reset = 1'b0;
    #1;
    chk("async_rst_valid", 65'(o_valid), 65'(0));
    chk("async_rst_result", o_result, 65'(0));
    chk("async_rst_class", 65'(o_class), 65'(0));
    chk("async_rst_tag", 65'(o_tag), 65'(0));
    @(negedge clock);
    reset = 1'b1;
    ir = 1'b1;
    repeat (4) begin
      @(negedge clock);
      #1;
      chk("post_flush_valid", 65'(o_valid), 65'(0));
      chk("post_flush_ready", 65'(o_ready), 65'(1));
    end
    run(19, 1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_ext_pipe.md
Name: fp_ext_pipe

Overview:
- Pipelined, parametrised successor of the FPU operand-extension stage.
- Unpacks half, single or double operands from a 64-bit FP register into the unified 65-bit internal format {sign, 12-bit exp biased 2047, 52-bit fraction}.
- Subnormals are normalised with an internal leading-zero counter, so no external LZC is needed.
- Produces the RISC-V FCLASS vector, checks NaN-boxing, and carries a tag through a 2-stage valid/ready pipeline between operand read and the FPU execute units.

Parameters:
- TAG_W, 4, width of the opaque tag carried alongside each operand.
- NANBOX_CHK, 1, when 1 an improperly NaN-boxed half/single input is replaced by the canonical qNaN.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- fp_ext_pipe_i_valid  input  1  input operand valid.
- fp_ext_pipe_o_ready  output  1  input stage can accept.
- fp_ext_pipe_i_data  input  64  raw register value.
- fp_ext_pipe_i_fmt  input  2  0=single, 1=double, 2=half, 3=reserved.
- fp_ext_pipe_i_tag  input  TAG_W  tag.
- fp_ext_pipe_o_valid  output  1  result valid.
- fp_ext_pipe_i_ready  input  1  consumer accepts.
- fp_ext_pipe_o_result  output  65  extended operand.
- fp_ext_pipe_o_classification  output  10  FCLASS one-hot.
- fp_ext_pipe_o_illegal  output  1  fmt==3 was presented.
- fp_ext_pipe_o_tag  output  TAG_W  tag of the result.

Behaviour:
- Reset (async, reset low): both stage valids, every output data register and o_illegal clear to 0. o_ready reads 1 once reset is released.
- Stage S1 registers sign, exponent, fraction (left-justified to 52 bits), fmt, tag, box-check result and LZC count.
- Stage S2 registers the normalised result, classification and illegal flag. The S2 register drives the outputs.
- Latency is 2 cycles at full throughput, 1 transfer per cycle.
- Transfer rules: in on i_valid&o_ready; out on o_valid&i_ready.
- S2 loads when it is empty or being drained. S1 loads when empty or moving to S2.
- o_ready = !s1_valid | s2_load. This is combinational from i_ready.
- Stalled data holds stable. Simultaneous in/out transfers in one cycle keep the pipeline full with no bubble.
- Field sources: fraction is single [22:0], double [51:0], half [9:0]. Bias offset to 2047 is single 0x780, double 0x400, half 0x7F0.
- Exponent all ones: exp=0xFFF, fraction copied.
- Normal: exp = field + offset.
- Zero: exp=0, fraction 0.
- Subnormal: k = leading zeros of the fraction field + 1. exp = offset + 1 − k. fraction = (field << k), truncated to width and left-justified.
- Fraction bits below the format width are always 0.
- NaN-box: with NANBOX_CHK=1, single requires data[63:32] all ones and half requires data[63:16] all ones. On failure the result is 0_FFF_8000000000000 and class is 0x200.
- Class bits:
  - 0 −inf, 1 −normal, 2 −subnormal, 3 −zero.
  - 4 +zero, 5 +subnormal, 6 +normal, 7 +inf.
  - 8 sNaN (fraction MSB 0), 9 qNaN.
  - Exactly one bit is set for legal formats.
- fmt==3: result 0, class 0, o_illegal=1. It is transferred like any other operand.
- Reset mid-operation drops all in-flight operands. No output is produced for them.

Test Plan:
- Single 1.0, data 0xFFFFFFFF3F800000 fmt 0 tag 5 → two cycles later o_valid, result 65'h07FF0000000000000, class 0x040, tag 5.
- Double −0.0, data 0x8000000000000000 fmt 1 → result 65'h10000000000000000, class 0x008.
- Single min subnormal 0xFFFFFFFF00000001 → exp 0x76A, fraction 0, class 0x020. Single subnormal 0xFFFFFFFF00400000 → exp 0x780, class 0x020.
- Half sNaN 0xFFFFFFFFFFFF7C01 fmt 2 → result 65'h0FFF0040000000000, class 0x100. Unboxed single 0x000000003F800000 → 65'h0FFF8000000000000, class 0x200.
- Back-to-back stream of 8 operands with i_ready toggled 1,0,0,1 → no loss, no duplication, order and tags preserved, outputs stable while stalled. o_ready falls only when both stages are full and i_ready=0.
- fmt 3 → o_illegal=1, class 0. Assert reset while 2 operands are in flight → o_valid=0 immediately, no stale outputs after release.
